// File: rtl/regfile_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_port_arbiter_if
//  Description : Writeback, game-logic request and register-file write-port
//                signals shared by the register-file port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_port_arbiter_if;
    logic        cpu_we;
    logic [4:0]  cpu_waddr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;

    logic        score_req;
    logic [31:0] score_data;
    logic        score_ack;

    logic        type_req;
    logic [31:0] type_data;
    logic        type_ack;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [31:0] score_add;
    logic        score_add_vld;
    logic [31:0] type_chg;
    logic        type_chg_vld;

    // Environment side: writeback stage, game logic and register file.
    modport master (
        output cpu_we, cpu_waddr, cpu_wdata,
        output score_req, score_data, type_req, type_data,
        input  cpu_stall, score_ack, type_ack,
        input  rf_we, rf_waddr, rf_wdata,
        input  score_add, score_add_vld, type_chg, type_chg_vld
    );

    // Arbiter side.
    modport slave (
        input  cpu_we, cpu_waddr, cpu_wdata,
        input  score_req, score_data, type_req, type_data,
        output cpu_stall, score_ack, type_ack,
        output rf_we, rf_waddr, rf_wdata,
        output score_add, score_add_vld, type_chg, type_chg_vld
    );
endinterface
`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_port_arbiter
//  Description : Shares the register-file write port between CPU writeback and
//                the score / tetromino-type producers, with anti-starvation
//                stall and snooping of CPU writes into game-logic events.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_port_arbiter #(
    parameter int unsigned MAX_WAIT     = 4,
    parameter int unsigned SCORE_REG    = 1,
    parameter int unsigned TYPE_REG     = 3,
    parameter int unsigned SCOREADD_REG = 2,
    parameter int unsigned TYPECHG_REG  = 4
) (
    input  logic                   clock,
    input  logic                   ctrl_reset,
    regfile_port_arbiter_if.slave  bus
);

    localparam logic [3:0] c_max_wait     = 4'(MAX_WAIT);
    localparam logic [4:0] c_score_reg    = 5'(SCORE_REG);
    localparam logic [4:0] c_type_reg     = 5'(TYPE_REG);
    localparam logic [4:0] c_scoreadd_reg = 5'(SCOREADD_REG);
    localparam logic [4:0] c_typechg_reg  = 5'(TYPECHG_REG);
    localparam logic       c_ptr_score    = 1'b0;
    localparam logic       c_ptr_type     = 1'b1;

    logic        r_ptr;
    logic [3:0]  r_wait_cnt;
    logic        r_score_ack;
    logic        r_type_ack;
    logic [31:0] r_score_add;
    logic        r_score_add_vld;
    logic [31:0] r_type_chg;
    logic        r_type_chg_vld;

    logic        w_cpu_wr;
    logic        w_score_elig;
    logic        w_type_elig;
    logic        w_any_elig;
    logic        w_forced;
    logic        w_grant_cpu;
    logic        w_grant_score;
    logic        w_grant_type;
    logic        w_game_grant;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;

    // Grants are gated by reset so the write port goes quiet the moment
    // reset asserts, not just at the next edge.
    always_comb begin
        w_cpu_wr      = 1'b0;
        w_score_elig  = 1'b0;
        w_type_elig   = 1'b0;
        w_any_elig    = 1'b0;
        w_forced      = 1'b0;
        w_grant_cpu   = 1'b0;
        w_grant_score = 1'b0;
        w_grant_type  = 1'b0;
        w_game_grant  = 1'b0;
        w_rf_we       = 1'b0;
        w_rf_waddr    = '0;
        w_rf_wdata    = '0;

        if (!ctrl_reset) begin
            w_cpu_wr     = bus.cpu_we && (bus.cpu_waddr != 5'd0);
            w_score_elig = bus.score_req && !r_score_ack;
            w_type_elig  = bus.type_req && !r_type_ack;
            w_any_elig   = w_score_elig || w_type_elig;
            w_forced     = w_any_elig && (r_wait_cnt == c_max_wait);
            w_grant_cpu  = w_cpu_wr && !w_forced;
            w_game_grant = w_any_elig && !w_grant_cpu;

            if (w_game_grant) begin
                if (w_score_elig && w_type_elig) begin
                    w_grant_score = (r_ptr == c_ptr_score);
                    w_grant_type  = (r_ptr == c_ptr_type);
                end else begin
                    w_grant_score = w_score_elig;
                    w_grant_type  = w_type_elig;
                end
            end

            if (w_grant_cpu) begin
                w_rf_we    = 1'b1;
                w_rf_waddr = bus.cpu_waddr;
                w_rf_wdata = bus.cpu_wdata;
            end else if (w_grant_score) begin
                w_rf_we    = 1'b1;
                w_rf_waddr = c_score_reg;
                w_rf_wdata = bus.score_data;
            end else if (w_grant_type) begin
                w_rf_we    = 1'b1;
                w_rf_waddr = c_type_reg;
                w_rf_wdata = bus.type_data;
            end
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_ptr       <= c_ptr_score;
            r_wait_cnt  <= 4'd0;
            r_score_ack <= 1'b0;
            r_type_ack  <= 1'b0;
        end else begin
            r_score_ack <= w_grant_score;
            r_type_ack  <= w_grant_type;

            if (w_grant_score) begin
                r_ptr <= c_ptr_type;
            end else if (w_grant_type) begin
                r_ptr <= c_ptr_score;
            end

            // Saturating loss counter; a request that lost to the CPU ages it.
            if (w_game_grant) begin
                r_wait_cnt <= 4'd0;
            end else if (w_any_elig && (r_wait_cnt != c_max_wait)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    // Snoop only committed CPU writes; a stalled write leaves no trace.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_score_add     <= '0;
            r_score_add_vld <= 1'b0;
            r_type_chg      <= '0;
            r_type_chg_vld  <= 1'b0;
        end else begin
            r_score_add_vld <= 1'b0;
            r_type_chg_vld  <= 1'b0;
            if (w_grant_cpu && (bus.cpu_waddr == c_scoreadd_reg)) begin
                r_score_add     <= bus.cpu_wdata;
                r_score_add_vld <= 1'b1;
            end
            if (w_grant_cpu && (bus.cpu_waddr == c_typechg_reg)) begin
                r_type_chg     <= bus.cpu_wdata;
                r_type_chg_vld <= 1'b1;
            end
        end
    end

    assign bus.cpu_stall     = w_forced;
    assign bus.rf_we         = w_rf_we;
    assign bus.rf_waddr      = w_rf_waddr;
    assign bus.rf_wdata      = w_rf_wdata;
    assign bus.score_ack     = r_score_ack;
    assign bus.type_ack      = r_type_ack;
    assign bus.score_add     = r_score_add;
    assign bus.score_add_vld = r_score_add_vld;
    assign bus.type_chg      = r_type_chg;
    assign bus.type_chg_vld  = r_type_chg_vld;

endmodule
`default_nettype wire
